// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dffnrq_pipe.sv
// Negative-edge multi-stage register pipeline with per-stage valids, hold enable and occupancy count.
// Optional scan chain through every data/valid bit: define GF180MCU_DFFN_PIPE_SCAN_CHAIN_EN.

module gf180mcu_fd_sc_mcu9t5v0__dffnrq_pipe_stage #(
  parameter int W = 9
) (
  input  logic         clkn,
  input  logic         rn,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // Ternary rather than if: an unknown enable merges d and q to X.
  always_ff @(negedge clkn or negedge rn)
    if (!rn) q <= '0;
    else     q <= en ? d : q;
endmodule

module gf180mcu_fd_sc_mcu9t5v0__dffnrq_pipe #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int OCC_W = $clog2(DEPTH+1)
) (
  input  logic             CLKN,
  input  logic             RN,
  input  logic             E,
  input  logic [WIDTH-1:0] D,
  input  logic             VLD_IN,
  output logic [WIDTH-1:0] Q,
  output logic             VLD_OUT,
  output logic [OCC_W-1:0] OCC
`ifdef GF180MCU_DFFN_PIPE_SCAN_CHAIN_EN
  ,
  input  logic             SE,
  input  logic             SI,
  output logic             SO
`endif
);
  // Each stage word is {valid, data}; valid sits at bit WIDTH.
  logic [DEPTH-1:0][WIDTH:0] st_q, st_d, shf_d;
  logic                      adv;
  logic [OCC_W-1:0]          occ_nxt;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign shf_d[i] = {VLD_IN, D};
    end else begin : g_body
      assign shf_d[i] = st_q[i-1];
    end

    gf180mcu_fd_sc_mcu9t5v0__dffnrq_pipe_stage #(.W(WIDTH+1)) u_stage (
      .clkn (CLKN),
      .rn   (RN),
      .en   (adv),
      .d    (st_d[i]),
      .q    (st_q[i])
    );
  end

`ifdef GF180MCU_DFFN_PIPE_SCAN_CHAIN_EN
  assign adv = E | SE;

  // Serial order inside a stage: data[0] .. data[WIDTH-1], then valid, then next stage.
  for (genvar i = 0; i < DEPTH; i++) begin : g_scan
    logic sin;
    if (i == 0) begin : g_si
      assign sin = SI;
    end else begin : g_link
      assign sin = st_q[i-1][WIDTH];
    end
    assign st_d[i] = SE ? {st_q[i][WIDTH-1:0], sin} : shf_d[i];
  end

  assign SO = st_q[DEPTH-1][WIDTH];
`else
  assign adv  = E;
  assign st_d = shf_d;
`endif

  always_comb begin
    occ_nxt = adv ? OCC + OCC_W'(VLD_IN) - OCC_W'(st_q[DEPTH-1][WIDTH]) : OCC;
`ifdef GF180MCU_DFFN_PIPE_SCAN_CHAIN_EN
    // A scan shift moves each stage's top data bit into its valid slot.
    if (SE) begin
      occ_nxt = '0;
      for (int i = 0; i < DEPTH; i++)
        occ_nxt = occ_nxt + OCC_W'(st_q[i][WIDTH-1]);
    end
`endif
  end

  always_ff @(negedge CLKN or negedge RN)
    if (!RN) OCC <= '0;
    else     OCC <= occ_nxt;

  assign Q       = st_q[DEPTH-1][WIDTH-1:0];
  assign VLD_OUT = st_q[DEPTH-1][WIDTH];
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__dffnrq_pipe.sv
// Scoreboard bench: driver pushes hand-computed per-edge expectations, monitor pops and compares.
// Covers a DEPTH=4 instance and a DEPTH=1 instance fed the same data; scan phase when the macro is set.

module tb_gf180mcu_fd_sc_mcu9t5v0__dffnrq_pipe;
  logic       CLKN = 1'b1;
  logic       RN   = 1'b1;
  logic       E    = 1'b1;
  logic [7:0] D    = '0;
  logic       VLD_IN = 1'b0;
  logic [7:0] Q, q1;
  logic       VLD_OUT, vo1;
  logic [2:0] OCC;
  logic       occ1;
`ifdef GF180MCU_DFFN_PIPE_SCAN_CHAIN_EN
  logic SE = 1'b0, SI = 1'b0, SO;
  logic se1 = 1'b0, si1 = 1'b0, so1;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string      tag;
    logic [7:0] q;
    logic       v;
    logic [2:0] occ;
    logic [7:0] q1;
  } exp_t;
  exp_t sb[$];

  always #5 CLKN = ~CLKN;

  gf180mcu_fd_sc_mcu9t5v0__dffnrq_pipe #(.WIDTH(8), .DEPTH(4)) dut (
    .CLKN(CLKN), .RN(RN), .E(E), .D(D), .VLD_IN(VLD_IN),
    .Q(Q), .VLD_OUT(VLD_OUT), .OCC(OCC)
`ifdef GF180MCU_DFFN_PIPE_SCAN_CHAIN_EN
    , .SE(SE), .SI(SI), .SO(SO)
`endif
  );

  gf180mcu_fd_sc_mcu9t5v0__dffnrq_pipe #(.WIDTH(8), .DEPTH(1)) dut1 (
    .CLKN(CLKN), .RN(RN), .E(E), .D(D), .VLD_IN(VLD_IN),
    .Q(q1), .VLD_OUT(vo1), .OCC(occ1)
`ifdef GF180MCU_DFFN_PIPE_SCAN_CHAIN_EN
    , .SE(se1), .SI(si1), .SO(so1)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One falling edge with the given inputs; expectation is the state after that edge.
  task automatic step(input string tag, input logic rn, input logic e, input logic v,
                      input logic [7:0] d, input logic [7:0] eq, input logic ev,
                      input logic [2:0] eo, input logic [7:0] eq1);
    exp_t x;
    RN = rn; E = e; VLD_IN = v; D = d;
    x.tag = tag; x.q = eq; x.v = ev; x.occ = eo; x.q1 = eq1;
    sb.push_back(x);
    @(negedge CLKN);
    @(posedge CLKN);
    #1;
  endtask

  // Monitor samples mid-period, well away from the falling edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge CLKN);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check({x.tag, ".q"},   32'(Q),       32'(x.q));
        check({x.tag, ".vld"}, 32'(VLD_OUT), 32'(x.v));
        check({x.tag, ".occ"}, 32'(OCC),     32'(x.occ));
        check({x.tag, ".q1"},  32'(q1),      32'(x.q1));
      end
    end
  end

  initial begin
    // Reset asserted before any clock edge, with busy inputs.
    D = 8'hFF; VLD_IN = 1'b1;
    #1 RN = 1'b0;
    #1;
    check("rst_pre_edge.q",   32'(Q),       32'h0);
    check("rst_pre_edge.vld", 32'(VLD_OUT), 32'h0);
    check("rst_pre_edge.occ", 32'(OCC),     32'h0);
    for (int i = 0; i < 3; i++) step("rst_hold", 0, 1, 1, 8'hFF, 8'h00, 0, 0, 8'h00);

    // Latency: one valid word, then bubbles.
    step("lat0", 1, 1, 1, 8'hA5, 8'h00, 0, 1, 8'hA5);
    step("lat1", 1, 1, 0, 8'h00, 8'h00, 0, 1, 8'h00);
    step("lat2", 1, 1, 0, 8'h00, 8'h00, 0, 1, 8'h00);
    step("lat3", 1, 1, 0, 8'h00, 8'hA5, 1, 1, 8'h00);
    step("lat4", 1, 1, 0, 8'h00, 8'h00, 0, 0, 8'h00);

    // Fill with 01..04, hold 5 edges while inputs are busy, then resume.
    step("fill1", 1, 1, 1, 8'h01, 8'h00, 0, 1, 8'h01);
    step("fill2", 1, 1, 1, 8'h02, 8'h00, 0, 2, 8'h02);
    step("fill3", 1, 1, 1, 8'h03, 8'h00, 0, 3, 8'h03);
    step("fill4", 1, 1, 1, 8'h04, 8'h01, 1, 4, 8'h04);
    for (int i = 0; i < 5; i++) step("hold", 1, 0, 1, 8'hFF, 8'h01, 1, 4, 8'h04);
    step("resume", 1, 1, 0, 8'h05, 8'h02, 1, 3, 8'h05);

    // Asynchronous reset between edges with OCC=3.
    RN = 1'b0;
    #1;
    check("rst_async.q",   32'(Q),       32'h0);
    check("rst_async.vld", 32'(VLD_OUT), 32'h0);
    check("rst_async.occ", 32'(OCC),     32'h0);
    check("rst_async.q1",  32'(q1),      32'h0);
    step("rst_mid", 0, 1, 1, 8'h77, 8'h00, 0, 0, 8'h00);

    // Release coincident with a falling edge: nothing observable is captured.
    begin
      exp_t x;
      E = 1'b1; VLD_IN = 1'b0; D = 8'h00;
      x.tag = "rst_release"; x.q = 8'h00; x.v = 1'b0; x.occ = 3'd0; x.q1 = 8'h00;
      sb.push_back(x);
      @(negedge CLKN);
      RN = 1'b1;
      @(posedge CLKN);
      #1;
    end

    // Full pipe: continuous valid input, OCC saturates at DEPTH.
    step("full_pre", 1, 1, 1, 8'h11, 8'h00, 0, 1, 8'h11);
    for (int i = 0; i < 10; i++)
      step("full", 1, 1, 1, 8'(8'h20 + i),
           (i < 2) ? 8'h00 : (i == 2) ? 8'h11 : 8'(8'h20 + i - 3),
           (i >= 2), (i < 2) ? 3'(2 + i) : 3'd4, 8'(8'h20 + i));

`ifdef GF180MCU_DFFN_PIPE_SCAN_CHAIN_EN
    // Scan with E=0: 36-bit chain, pattern 1,0,1,... reappears on SO from edge 36.
    E = 1'b0; SE = 1'b1;
    for (int e = 1; e <= 44; e++) begin
      SI = ((e - 1) % 2 == 0);
      @(negedge CLKN);
      @(posedge CLKN);
      #1;
      if (e >= 36) check("scan_so", 32'(SO), 32'(((e - 36) % 2) == 0));
      if (e == 36) check("scan_occ", 32'(OCC), 32'd2);
    end
    SE = 1'b0; E = 1'b1;
    RN = 1'b0;
    #1 RN = 1'b1;
    step("post_scan0", 1, 1, 1, 8'h5A, 8'h00, 0, 1, 8'h5A);
    step("post_scan1", 1, 1, 0, 8'h00, 8'h00, 0, 1, 8'h00);
    step("post_scan2", 1, 1, 0, 8'h00, 8'h00, 0, 1, 8'h00);
    step("post_scan3", 1, 1, 0, 8'h00, 8'h5A, 1, 1, 8'h00);
`endif

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge CLKN);
    #1;
    if (sb.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
